// File: rtl/dbg_pkg.sv
// Shared constants and types for the two-requester debug-port arbiter.
package dbg_pkg;

  localparam int       NUM_REQ         = 2;
  localparam int       TIMEOUT_DEFAULT = 1024;
  localparam logic [7:0] CMD_IDLE      = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } dbg_state_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbg_req_t;

endpackage

// File: rtl/dbg_rr_arb.sv
// Two-way round-robin picker; i_last is the index of the requester served last.
module dbg_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dbg_arbiter.sv
// Arbitrates two debug requesters onto one core debug port with a 4-phase
// ready handshake, illegal-command rejection and an ISSUE timeout.
module dbg_arbiter
  import dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [15:0] cmd_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // Reset asserts immediately, releases two clock edges later.
  logic [1:0] r_rst_sync;
  logic       w_rst;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) r_rst_sync <= 2'b11;
    else       r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  dbg_req_t [NUM_REQ-1:0] w_req_pl;
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_pl
    assign w_req_pl[n] = '{cmd:   cmd_i[8*n +: 8],
                           addr:  addr_i[32*n +: 32],
                           wdata: wdata_i[32*n +: 32]};
  end

  logic [1:0] w_grant;
  logic       r_last;
  dbg_req_t   w_sel;

  dbg_rr_arb u_arb (
    .i_req   (req_i),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_sel = w_grant[1] ? w_req_pl[1] : w_req_pl[0];

  dbg_state_e    r_state;
  logic [1:0]    r_gnt, r_done, r_err;
  logic [31:0]   r_rdata, r_addr, r_data;
  logic [7:0]    r_cmd;
  logic          r_busy, r_illegal;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge sys_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_cmd     <= CMD_IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_gnt     <= w_grant;
            r_last    <= w_grant[1];
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_illegal <= (w_sel.cmd == CMD_IDLE);
            r_state   <= ST_ISSUE;
            // An illegal command never reaches the core, so leave the port quiet.
            if (w_sel.cmd != CMD_IDLE) begin
              r_cmd  <= w_sel.cmd;
              r_addr <= w_sel.addr;
              r_data <= w_sel.wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (r_illegal) begin
            r_done    <= r_gnt;
            r_err     <= r_gnt;
            r_rdata   <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (dbg_ready_i) begin
            // Ready wins over a timeout landing on the same cycle.
            r_rdata <= dbg_data_i;
            r_done  <= r_gnt;
            r_cmd   <= CMD_IDLE;
            r_state <= ST_RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata <= '0;
            r_done  <= r_gnt;
            r_err   <= r_gnt;
            r_cmd   <= CMD_IDLE;
            r_state <= ST_RELEASE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (!dbg_ready_i) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_cmd   <= CMD_IDLE;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o      = r_gnt;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign rdata_o    = r_rdata;
  assign busy_o     = r_busy;
  assign dbg_cmd_o  = r_cmd;
  assign dbg_addr_o = r_addr;
  assign dbg_data_o = r_data;

endmodule

// File: tb/tb_dbg_arbiter.sv
// Randomized transaction-level bench for dbg_arbiter: round-robin winner,
// completion cycle, error class and captured data come from a simple model.
module tb_dbg_arbiter;
  import dbg_pkg::*;

  localparam int TO = 16;

  logic        sys_clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [15:0] cmd_i;
  logic [63:0] addr_i, wdata_i;
  logic [1:0]  gnt_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o, dbg_data_o, dbg_data_i;
  logic        dbg_ready_i;

  dbg_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .sys_clk_i   (sys_clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .cmd_i       (cmd_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .busy_o      (busy_o),
    .dbg_cmd_o   (dbg_cmd_o),
    .dbg_addr_o  (dbg_addr_o),
    .dbg_data_o  (dbg_data_o),
    .dbg_data_i  (dbg_data_i),
    .dbg_ready_i (dbg_ready_i)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_srv;
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One full transaction: present requests, play the core with a ready
  // delay of dly ISSUE cycles, then hold ready for `hold` release cycles.
  task automatic run_txn(input logic [1:0] req, input logic [7:0] c0, input logic [7:0] c1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input int dly, input logic [31:0] rdat, input int hold);
    int          win, exp_e, e;
    logic [1:0]  oh;
    logic [7:0]  wc;
    logic [31:0] wa, ww;
    bit          illegal, tmo, got, stable;
    win      = (req == 2'b11) ? 1 - last_srv : (req[1] ? 1 : 0);
    last_srv = win;
    oh       = 2'(1 << win);
    wc       = (win == 1) ? c1 : c0;
    wa       = (win == 1) ? a1 : a0;
    ww       = (win == 1) ? w1 : w0;
    illegal  = (wc == CMD_IDLE);
    tmo      = !illegal && (dly >= TO);
    exp_e    = illegal ? 1 : (tmo ? TO : dly + 1);

    @(negedge sys_clk_i);
    req_i = req; cmd_i = {c1, c0}; addr_i = {a1, a0}; wdata_i = {w1, w0};
    dbg_ready_i = 1'b0;
    @(posedge sys_clk_i); #1;
    chk("gnt", gnt_o, oh);
    chk("busy_grant", busy_o, 1);
    chk("done_grant", done_o, 0);
    chk("rdata_hold", rdata_o, exp_rdata);
    chk("cmd_issue", dbg_cmd_o, wc);
    if (!illegal) begin
      chk("addr_issue", dbg_addr_o, wa);
      chk("data_issue", dbg_data_o, ww);
    end

    got = 0; stable = 1; e = 0;
    while (!got && e < TO + 4) begin
      e++;
      @(negedge sys_clk_i);
      req_i   = 2'($urandom);
      cmd_i   = 16'($urandom);
      addr_i  = {$urandom, $urandom};
      wdata_i = {$urandom, $urandom};
      dbg_ready_i = !illegal && (e >= dly + 1);
      dbg_data_i  = dbg_ready_i ? rdat : $urandom;
      @(posedge sys_clk_i); #1;
      if (done_o != 2'b00) got = 1;
      else if (dbg_cmd_o != wc || gnt_o != oh || err_o != 2'b00) stable = 0;
    end
    chk("done_seen", got, 1);
    chk("issue_stable", stable, 1);
    chk("done_cycle", e, exp_e);
    chk("done", done_o, oh);
    chk("err", err_o, (illegal || tmo) ? oh : 2'b00);
    exp_rdata = (illegal || tmo) ? 32'h0 : rdat;
    chk("rdata", rdata_o, exp_rdata);
    chk("cmd_release", dbg_cmd_o, CMD_IDLE);

    @(negedge sys_clk_i);
    req_i = 2'b00;
    if (illegal) begin
      chk("gnt_illegal", gnt_o, 0);
      chk("busy_illegal", busy_o, 0);
    end else begin
      chk("busy_release", busy_o, 1);
      for (int r = 0; r < hold && dbg_ready_i; r++) begin
        @(posedge sys_clk_i); #1;
        chk("hold_gnt", gnt_o, oh);
        chk("hold_pulse", done_o, 0);
        chk("hold_cmd", dbg_cmd_o, CMD_IDLE);
        @(negedge sys_clk_i);
      end
      dbg_ready_i = 1'b0;
      @(posedge sys_clk_i); #1;
      chk("idle_gnt", gnt_o, 0);
      chk("idle_busy", busy_o, 0);
    end
  endtask

  function automatic logic [7:0] rnd_cmd();
    return ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; req_i = '0; cmd_i = '0; addr_i = '0; wdata_i = '0;
    dbg_data_i = '0; dbg_ready_i = 1'b0;
    last_srv = 1; exp_rdata = '0;
    repeat (3) @(posedge sys_clk_i);
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cmd", dbg_cmd_o, 0);
    chk("rst_addr", dbg_addr_o, 0);
    chk("rst_data", dbg_data_o, 0);
    @(negedge sys_clk_i);
    rst_i = 1'b0;
    repeat (3) @(posedge sys_clk_i);

    // Simultaneous requests alternate 0,1,0,1 starting with requester 0.
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 8'h10 + 8'(i), 8'h20 + 8'(i), $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 4), $urandom, $urandom_range(0, 2));

    run_txn(2'b01, 8'h01, 8'h55, 32'h1000_0000, 32'h2000_0000, 32'h1111_1111, 32'h2222_2222,
            3, 32'hDEAD_BEEF, 2);
    run_txn(2'b10, 8'h07, 8'h00, 32'h0, 32'h3000_0000, 32'h0, 32'h0, 0, 32'hAAAA_5555, 0);
    run_txn(2'b01, 8'h02, 8'h00, 32'h4000_0000, 32'h0, 32'h1234_5678, 32'h0, 40, 32'h5A5A_5A5A, 0);
    run_txn(2'b10, 8'h00, 8'h03, 32'h0, 32'h5000_0000, 32'h0, 32'h8765_4321, TO - 1, 32'hCAFE_F00D, 1);

    // Reset during ISSUE: immediate output clear, no completion pulse.
    @(negedge sys_clk_i);
    req_i = 2'b01; cmd_i = 16'h005A; addr_i = 64'h1; wdata_i = 64'h2;
    @(posedge sys_clk_i); #1;
    chk("mid_gnt", gnt_o, 2'b01);
    @(negedge sys_clk_i);
    req_i = 2'b00;
    repeat (3) @(posedge sys_clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cmd", dbg_cmd_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    repeat (2) @(negedge sys_clk_i);
    rst_i = 1'b0;
    repeat (4) begin
      @(posedge sys_clk_i); #1;
      chk("post_rst_done", done_o, 0);
    end
    last_srv = 1; exp_rdata = '0;
    run_txn(2'b11, 8'h09, 8'h0A, 32'hA000_0000, 32'hB000_0000, 32'h1, 32'h2, 2, 32'h0BAD_F00D, 1);

    for (int i = 0; i < 60; i++) begin
      int dly;
      case ($urandom_range(0, 3))
        0:       dly = TO - 1;
        1:       dly = $urandom_range(TO, TO + 4);
        default: dly = $urandom_range(0, 8);
      endcase
      run_txn(2'($urandom_range(1, 3)), rnd_cmd(), rnd_cmd(), $urandom, $urandom,
              $urandom, $urandom, dly, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
